// File: rtl/lut_neuron_prog_pkg.sv
// rtl/lut_neuron_prog_pkg.sv - shared FSM state type and default widths for the programmable LUT neuron
package lut_neuron_prog_pkg;

  localparam int DEF_IN_BITS  = 6;
  localparam int DEF_OUT_BITS = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_t;

endpackage

// File: rtl/lut_neuron_table.sv
// rtl/lut_neuron_table.sv - flop-based 2^IN_BITS x OUT_BITS table with write port and registered read
module lut_neuron_table #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [IN_BITS-1:0]  waddr,
  input  logic [OUT_BITS-1:0] wdata,
  input  logic                re,
  input  logic [IN_BITS-1:0]  raddr,
  output logic                rvalid,
  output logic [OUT_BITS-1:0] rdata
);

  localparam int DEPTH = 1 << IN_BITS;

  logic [OUT_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A read on the same edge as a write returns the pre-write contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= re;
      if (re) rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/lut_neuron_prog.sv
// rtl/lut_neuron_prog.sv - writable LUT neuron: streamed table load FSM plus 1-cycle lookup path
module lut_neuron_prog
  import lut_neuron_prog_pkg::*;
#(
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_start,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [OUT_BITS-1:0] ld_data,
  input  logic                ld_last,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data,
  output logic                loaded,
  output logic                ld_err
);

  localparam logic [IN_BITS-1:0] LAST_ADDR = '1;

  state_t             state;
  logic [IN_BITS-1:0] addr;
  logic               xfer;
  logic               lookup;
  logic               we;

  assign ld_ready = (state == ST_LOAD);
  assign in_ready = (state == ST_READY);
  assign xfer     = ld_valid && ld_ready;
  assign lookup   = in_valid && in_ready;
  // A restart wins over a beat presented on the same edge.
  assign we       = xfer && !ld_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_EMPTY;
      addr   <= '0;
      loaded <= 1'b0;
      ld_err <= 1'b0;
    end else if (ld_start) begin
      state  <= ST_LOAD;
      addr   <= '0;
      loaded <= 1'b0;
      ld_err <= 1'b0;
    end else if (xfer) begin
      if (addr == LAST_ADDR) begin
        if (ld_last) begin
          state  <= ST_READY;
          loaded <= 1'b1;
        end else begin
          state  <= ST_EMPTY;
          ld_err <= 1'b1;
        end
      end else if (ld_last) begin
        state  <= ST_EMPTY;
        ld_err <= 1'b1;
      end else begin
        addr <= addr + 1'b1;
      end
    end
  end

  lut_neuron_table #(
    .IN_BITS (IN_BITS),
    .OUT_BITS(OUT_BITS)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (addr),
    .wdata (ld_data),
    .re    (lookup),
    .raddr (in_data),
    .rvalid(out_valid),
    .rdata (out_data)
  );

endmodule

// File: doc/lut_neuron_prog.md
LUT_NEURON_PROG -- requirements
Module: lut_neuron_prog

Interface
REQ-001 The block SHALL have parameter IN_BITS, default 6, meaning the neuron input address width (fan-in x input bit-width).
REQ-002 The block SHALL have parameter OUT_BITS, default 2, meaning the quantized neuron output width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-005 The block SHALL have port ld_start, input, 1 bit: a pulse that begins a table load.
REQ-006 The block SHALL have port ld_valid, input, 1 bit: the load beat is valid.
REQ-007 The block SHALL have port ld_ready, output, 1 bit: the block accepts a load beat.
REQ-008 The block SHALL have port ld_data, input, OUT_BITS: the table entry for the current load address.
REQ-009 The block SHALL have port ld_last, input, 1 bit: the sender marks its final beat.
REQ-010 The block SHALL have port in_valid, input, 1 bit: a lookup request.
REQ-011 The block SHALL have port in_ready, output, 1 bit: the block accepts lookups.
REQ-012 The block SHALL have port in_data, input, IN_BITS: the lookup address (packed quantized inputs).
REQ-013 The block SHALL have port out_valid, output, 1 bit: the lookup result is valid.
REQ-014 The block SHALL have port out_data, output, OUT_BITS: the lookup result.
REQ-015 The block SHALL have port loaded, output, 1 bit: a complete table is resident.
REQ-016 The block SHALL have port ld_err, output, 1 bit: sticky flag set when a load ends short or long.

Function
REQ-017 The block SHALL hold a 2^IN_BITS x OUT_BITS table in flops, serving as the writable counterpart of the fixed-ROM neuron.
REQ-018 The FSM SHALL have the states EMPTY, LOAD and READY.
REQ-019 A ld_start pulse SHALL move the FSM to LOAD from any state and clear the write address to 0; ld_start in LOAD SHALL restart the load at address 0.
REQ-020 In LOAD the block SHALL drive ld_ready=1; in the other states ld_ready=0.
REQ-021 A beat SHALL transfer only when ld_valid&&ld_ready; on transfer, table[addr] SHALL take ld_data and addr SHALL increment.
REQ-022 A transfer at addr=2^IN_BITS-1 with ld_last=1 SHALL move the FSM to READY and set loaded=1.
REQ-023 A transfer at addr=2^IN_BITS-1 with ld_last=0, or with ld_last=1 at any lower addr, SHALL move the FSM to EMPTY, set ld_err, and leave loaded=0.
REQ-024 The write address SHALL never wrap.
REQ-025 Entering LOAD SHALL clear loaded on the next edge; ld_err SHALL clear only on ld_start or reset.
REQ-026 The block SHALL drive in_ready=1 only in READY.
REQ-027 A lookup accepted (in_valid&&in_ready) in cycle N SHALL produce out_valid=1 and out_data=table[in_data] in cycle N+1, so latency is 1 with full throughput.
REQ-028 Without an accepted lookup, out_valid SHALL return to 0 and out_data SHALL hold its value.
REQ-029 When ld_start coincides with an accepted lookup, the lookup SHALL complete from the old table and the load SHALL start on the same edge.

Reset
REQ-030 Reset SHALL immediately clear the FSM to EMPTY, addr to 0, all table entries to 0, and out_valid, out_data, loaded and ld_err to 0.
REQ-031 Reset during LOAD SHALL abandon the load; the sender SHALL restart it with ld_start.

Structure
REQ-032 A shared package SHALL hold the FSM state enum and the default IN_BITS/OUT_BITS constants.
REQ-033 The table storage with its write enable and registered read SHALL form one sub-module, lut_neuron_table.

Verification
REQ-034 The bench SHALL reset, then issue in_valid=1 -> in_ready=0, out_valid=0, loaded=0.
REQ-035 The bench SHALL load 64 beats with ld_data=addr[1:0] and ld_last on beat 63 -> loaded=1; lookup 6'b101010 -> out_data=2'b10 one cycle later.
REQ-036 The bench SHALL issue back-to-back lookups 0,1,2,3 on consecutive cycles -> out_data 0,1,2,3 on the following four cycles with out_valid held at 1.
REQ-037 The bench SHALL assert ld_last on beat 10 -> FSM EMPTY, ld_err=1, loaded=0, in_ready=0.
REQ-038 The bench SHALL assert rst at beat 30, then ld_start and a full load of all 2'b11 -> ld_err=0 and every lookup returns 2'b11.
REQ-039 The bench SHALL pulse ld_start together with a lookup at 6'h05 on the old table -> the old entry appears next cycle, then in_ready=0 and ld_ready=1.
